mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single byte-wide port of the external memory (exmem: addr/data/we in, registered q out) between
//  two requesters: port 0 = mips CPU, port 1 = loader/debug master. Round-robin arbitration with per-port lock
//  so a 4-byte instruction fetch or multi-byte load is never split. Sits between the requesters and exmem.
// PARAMETERS
//  DATA_WIDTH  8   memory data width
//  ADDR_WIDTH  8   memory address width
//  MEM_LAT     1   cycles from accepted read to valid mem_q (>=1)
//  MAX_HOLD    16  max consecutive owned cycles while other port waits (unlocked owner only), >=1
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           asynchronous, active-low reset
//  rN_req     in   1           port N (N=0,1) access request, one access per cycle while granted
//  rN_we      in   1           1 = write, 0 = read
//  rN_addr    in   ADDR_WIDTH  access address
//  rN_wdata   in   DATA_WIDTH  write data
//  rN_lock    in   1           hold ownership across idle cycles / beyond MAX_HOLD
//  rN_gnt     out  1           port N owns memory (registered)
//  rN_rdata   out  DATA_WIDTH  = mem_q; meaningful only when rN_rvalid
//  rN_rvalid  out  1           read data for port N valid this cycle
//  mem_addr   out  ADDR_WIDTH  to exmem addr
//  mem_wdata  out  DATA_WIDTH  to exmem data
//  mem_we     out  1           to exmem we
//  mem_q      in   DATA_WIDTH  from exmem q
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, r0_gnt=r1_gnt=0, rvalid pipeline cleared, hold_cnt=0, last=1.
//   Combinational outputs under reset: mem_we=0, mem_addr=0, mem_wdata=0. Mid-operation reset drops
//   in-flight reads (no rvalid issued) and aborts any lock.
//  States: IDLE, OWN0, OWN1. rN_gnt = (state==OWNN), registered.
//  IDLE: only r0_req -> OWN0; only r1_req -> OWN1; both -> port != last. No req -> stay. Grant visible
//   the cycle after req first seen (1-cycle arbitration latency); no memory access in IDLE.
//  OWNN: accepted access = rN_req & rN_gnt. mem_addr/mem_wdata = port N inputs; mem_we = rN_we & accept.
//   Not accepting: mem_we=0, mem_addr/mem_wdata = port N values (don't-care).
//   hold_cnt increments each OWN cycle (saturating at MAX_HOLD), clears on entry to an OWN state.
//  Leave OWNN -> IDLE when rN_lock=0 and (rN_req=0 or (other req=1 and hold_cnt==MAX_HOLD)).
//   last<=N on leaving. rN_lock=1 holds OWNN indefinitely, even with rN_req=0 (no accesses issued).
//   Forced release at MAX_HOLD: the access presented that cycle is still accepted; requester must keep
//   req high and re-arbitrate. Next IDLE cycle grants the other port (round-robin), 1 dead cycle on handoff.
//  Reads: accepted read pushes tag N into MEM_LAT-deep valid/tag shift register; rN_rvalid asserts exactly
//   MEM_LAT cycles later regardless of current ownership. Back-to-back reads -> back-to-back rvalids.
//   Writes produce no rvalid. Only one port's rvalid is high in any cycle.
//  Port N never sees mem_we driven from the other port's signals; ungranted req has no side effects.
// TESTING
//  1 reset low 3 cycles, r0_req=1 held -> r0_gnt=0, mem_we=0 during reset; r0_gnt=1 1 cycle after release.
//  2 r0 reads 0x00..0x03 with lock=1, r1_req=1 from cycle 1 -> 4 accepts to r0, r0_rvalid 4 consecutive
//    cycles MEM_LAT after each, data = mem contents; r1_gnt only after r0 drops lock and req, 1 idle cycle.
//  3 both req in IDLE, reset state -> r0 first; r0 releases, both req again -> r1 granted (round-robin).
//  4 r1 writes 0xA5 to 0x10 (unlocked), r0 waiting, MAX_HOLD=4 -> r1 forced off after 4 owned cycles,
//    r0 granted; subsequent r0 read of 0x10 returns 0xA5 with r0_rvalid, r1_rvalid stays 0.
//  5 r0 read accepted, reset asserted next cycle -> r0_rvalid never asserts, state IDLE, gnts 0.
//  6 r0 owns, lock=1, req=0 for 10 cycles with r1_req=1 -> r0_gnt held, mem_we=0, r1_gnt=0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin, lockable two-port arbiter for a single byte-wide
//             external memory port with a fixed read latency.
//  Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_LAT    = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic                  r0_lock,
    output logic                  r0_gnt,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_rvalid,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic                  r1_lock,
    output logic                  r1_gnt,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    localparam int                 c_CW        = $clog2(MAX_HOLD + 1);
    localparam logic [c_CW-1:0]    c_HOLD_MAX  = c_CW'(MAX_HOLD);
    localparam logic [c_CW-1:0]    c_HOLD_LAST = c_CW'(MAX_HOLD - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last;
    logic [c_CW-1:0]      r_hold_cnt;
    logic [MEM_LAT-1:0]   r_vld;
    logic [MEM_LAT-1:0]   r_tag;

    logic                 w_own;
    logic                 w_sel1;
    logic                 w_accept;
    logic                 w_we_sel;
    logic                 w_rd_push;
    logic                 w_hold_full;

    // r_hold_cnt counts owned cycles already completed, so the current cycle
    // is the MAX_HOLD-th owned one once it reaches MAX_HOLD-1.
    assign w_hold_full = (r_hold_cnt >= c_HOLD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_own       = 1'b0;
        w_sel1      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r0_req && (!r1_req || r_last)) begin
                    w_state_nxt = S_OWN0;
                end else if (r1_req) begin
                    w_state_nxt = S_OWN1;
                end
            end
            S_OWN0: begin
                w_own    = 1'b1;
                w_accept = r0_req;
                if (!r0_lock && (!r0_req || (r1_req && w_hold_full))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OWN1: begin
                w_own    = 1'b1;
                w_sel1   = 1'b1;
                w_accept = r1_req;
                if (!r1_lock && (!r1_req || (r0_req && w_hold_full))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_we_sel  = w_sel1 ? r1_we : r0_we;
    assign w_rd_push = w_accept && !w_we_sel;

    assign mem_addr  = (reset && w_own) ? (w_sel1 ? r1_addr  : r0_addr)  : '0;
    assign mem_wdata = (reset && w_own) ? (w_sel1 ? r1_wdata : r0_wdata) : '0;
    assign mem_we    = reset && w_accept && w_we_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Every OWN state is entered from IDLE, so clearing here clears on entry.
            if (r_state == S_IDLE) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != c_HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + c_CW'(1);
            end
            if ((r_state != S_IDLE) && (w_state_nxt == S_IDLE)) begin
                r_last <= (r_state == S_OWN1);
            end
        end
    end

    generate
        if (MEM_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vld <= '0;
                    r_tag <= '0;
                end else begin
                    r_vld <= w_rd_push;
                    r_tag <= w_sel1;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vld <= '0;
                    r_tag <= '0;
                end else begin
                    r_vld <= {r_vld[MEM_LAT-2:0], w_rd_push};
                    r_tag <= {r_tag[MEM_LAT-2:0], w_sel1};
                end
            end
        end
    endgenerate

    assign r0_gnt    = (r_state == S_OWN0);
    assign r1_gnt    = (r_state == S_OWN1);
    assign r0_rvalid = r_vld[MEM_LAT-1] && !r_tag[MEM_LAT-1];
    assign r1_rvalid = r_vld[MEM_LAT-1] &&  r_tag[MEM_LAT-1];
    assign r0_rdata  = mem_q;
    assign r1_rdata  = mem_q;

endmodule
`default_nettype wire
